// File: rtl/lane_frame_serializer.sv
// Buffers 50-bit lane/word/bus/tag samples in a FIFO and emits each as a frame of 8-bit beats with sof/eof.
// Optional macro LANE_FRAME_PARITY_EN appends an even-parity beat (8 beats per frame instead of 7).
module lane_frame_serializer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [9:0]  in_lane,
    input  logic [7:0]  in_word,
    input  logic [26:0] in_bus,
    input  logic [4:0]  in_tag,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_sof,
    output logic        out_eof,
    output logic [15:0] frame_cnt
);

    localparam int AW = $clog2(DEPTH);
`ifdef LANE_FRAME_PARITY_EN
    localparam int NBEATS = 8;
`else
    localparam int NBEATS = 7;
`endif
    localparam int SRW = NBEATS * 8;
    localparam logic [2:0] LAST_BEAT = 3'(NBEATS - 1);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t state, next_state;

    logic [49:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic [SRW-1:0] shreg, load_val;
    logic [2:0]     beat;
    logic [49:0]    frame_in, head;
    logic           full, empty, push, pop, beat_hs, last_hs;

    assign frame_in = {in_tag, in_bus, in_word, in_lane};
    assign head     = mem[rd_ptr];
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;

    // The shift register holds every beat of the frame so out_data is always its low byte.
`ifdef LANE_FRAME_PARITY_EN
    assign load_val = {7'b0, ^head, 6'b0, head};
`else
    assign load_val = {6'b0, head};
`endif

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        beat_hs    = 1'b0;
        last_hs    = 1'b0;
        out_valid  = 1'b0;
        out_data   = 8'h00;
        out_sof    = 1'b0;
        out_eof    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    next_state = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_data  = shreg[7:0];
                out_sof   = (beat == 3'd0);
                out_eof   = (beat == LAST_BEAT);
                if (out_ready) begin
                    beat_hs = 1'b1;
                    if (beat == LAST_BEAT) begin
                        last_hs = 1'b1;
                        // Chain straight into the next frame when one is waiting.
                        if (!empty) begin
                            pop = 1'b1;
                        end else begin
                            next_state = IDLE;
                        end
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= frame_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            beat      <= '0;
            frame_cnt <= '0;
        end else begin
            state <= next_state;
            if (pop) begin
                shreg <= load_val;
                beat  <= 3'd0;
            end else if (beat_hs) begin
                shreg <= shreg >> 8;
                beat  <= beat + 3'd1;
            end
            if (last_hs) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_lane_frame_serializer.sv
// Randomized self-checking bench for lane_frame_serializer against a frame-queue reference model.
module tb_lane_frame_serializer;

    localparam int DEPTH = 4;
`ifdef LANE_FRAME_PARITY_EN
    localparam int NB = 8;
`else
    localparam int NB = 7;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_lane;
    logic [7:0]  in_word;
    logic [26:0] in_bus;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_sof;
    logic        out_eof;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    logic [49:0] model_q[$];
    logic [15:0] model_cnt;

    logic [7:0] cap_data[$];
    bit         cap_sof[$];
    bit         cap_eof[$];
    int         cap_got, cap_gaps, cap_first, cap_cycles;

    lane_frame_serializer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_lane(in_lane), .in_word(in_word), .in_bus(in_bus), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sof(out_sof), .out_eof(out_eof), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Beat k of a frame: successive bytes of F counted from the LSB; the optional extra beat is F's parity.
    function automatic logic [7:0] exp_beat(input logic [49:0] f, input int k);
        logic [49:0] s;
        if (NB == 8 && k == 7) return 8'($countones(f) % 2);
        s = f >> (8 * k);
        return s[7:0];
    endfunction

    function automatic logic [49:0] rand_frame();
        return {18'($urandom), 32'($urandom)};
    endfunction

    task automatic applyStimulus(input logic [49:0] f, input int budget, output bit ok);
        ok = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        {in_tag, in_bus, in_word, in_lane} = f;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (in_ready) begin
                model_q.push_back(f);
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (ok) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic capture(input int nbeats, input int budget, input bit rand_ready);
        cap_data.delete(); cap_sof.delete(); cap_eof.delete();
        cap_got = 0; cap_gaps = 0; cap_first = -1; cap_cycles = 0;
        for (int c = 0; c < budget && cap_got < nbeats; c++) begin
            @(posedge clk); #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (cap_first >= 0) cap_cycles++;
            if (out_valid && out_ready) begin
                if (cap_first < 0) begin
                    cap_first  = c;
                    cap_cycles = 1;
                end
                cap_data.push_back(out_data);
                cap_sof.push_back(out_sof);
                cap_eof.push_back(out_eof);
                cap_got++;
            end else if (cap_first >= 0 && !out_valid) begin
                cap_gaps++;
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic retire_frames(input int n);
        logic [49:0] f;
        for (int j = 0; j < n; j++) begin
            f = model_q.pop_front();
            model_cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        {in_tag, in_bus, in_word, in_lane} = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 ||
            out_sof !== 1'b0 || out_eof !== 1'b0 || frame_cnt !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_values: got rdy=%b vld=%b data=%h sof=%b eof=%b cnt=%h, want 0 0 00 0 0 0000",
                     in_ready, out_valid, out_data, out_sof, out_eof, frame_cnt);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: got rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end
        model_q.delete();
        model_cnt = 16'h0;
    endtask

    task automatic test_single();
        bit ok;
        logic [49:0] f;
        logic [7:0] lit[7];
        lit = '{8'hA5, 8'h0E, 8'h97, 8'h96, 8'h96, 8'h76, 8'h02};
        f = {5'h13, 27'h5A5A5A5, 8'hC3, 10'h2A5};
        out_ready = 1'b1;
        applyStimulus(f, 5, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_accept: got accepted=%b, want 1", ok);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_latency_idle: got out_valid=%b, want 0", out_valid);
        end
        capture(NB, 20, 1'b0);
        checks++;
        if (cap_got != NB || cap_first != 0) begin
            errors++;
            $display("[TB] FAIL single_latency: got beats=%0d first=%0d, want %0d 0", cap_got, cap_first, NB);
        end
        for (int i = 0; i < cap_got; i++) begin
            checks++;
            if (cap_data[i] !== exp_beat(model_q[0], i) || (i < 7 && cap_data[i] !== lit[i]) ||
                cap_sof[i] !== (i == 0) || cap_eof[i] !== (i == NB - 1)) begin
                errors++;
                $display("[TB] FAIL single_beat %0d: got data=%h sof=%b eof=%b, want data=%h sof=%b eof=%b",
                         i, cap_data[i], cap_sof[i], cap_eof[i], exp_beat(model_q[0], i), i == 0, i == NB - 1);
            end
        end
        retire_frames(cap_got / NB);
        checks++;
        if (frame_cnt !== model_cnt) begin
            errors++;
            $display("[TB] FAIL single_frame_cnt: got %h, want %h", frame_cnt, model_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [49:0] f;
        f = rand_frame();
        applyStimulus(f, 5, ok);
        cap_data.delete(); cap_sof.delete(); cap_eof.delete();
        cap_got = 0;
        for (int c = 0; c < NB + 10 && cap_got < NB; c++) begin
            @(posedge clk); #1;
            out_ready = (c == 2 || c == 3) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (c >= 2 && c <= 4) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp_beat(f, 2) || out_sof !== 1'b0 || out_eof !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL stall_hold cyc %0d: got vld=%b data=%h sof=%b eof=%b, want 1 %h 0 0",
                             c, out_valid, out_data, out_sof, out_eof, exp_beat(f, 2));
                end
            end
            if (out_valid && out_ready) begin
                cap_data.push_back(out_data);
                cap_sof.push_back(out_sof);
                cap_eof.push_back(out_eof);
                cap_got++;
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (cap_got != NB) begin
            errors++;
            $display("[TB] FAIL stall_count: got %0d beats, want %0d", cap_got, NB);
        end
        for (int i = 0; i < cap_got; i++) begin
            checks++;
            if (cap_data[i] !== exp_beat(model_q[0], i) || cap_sof[i] !== (i == 0) || cap_eof[i] !== (i == NB - 1)) begin
                errors++;
                $display("[TB] FAIL stall_beat %0d: got data=%h sof=%b eof=%b, want data=%h sof=%b eof=%b",
                         i, cap_data[i], cap_sof[i], cap_eof[i], exp_beat(model_q[0], i), i == 0, i == NB - 1);
            end
        end
        retire_frames(cap_got / NB);
        checks++;
        if (frame_cnt !== model_cnt) begin
            errors++;
            $display("[TB] FAIL stall_frame_cnt: got %h, want %h", frame_cnt, model_cnt);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        for (int n = 0; n < 3; n++) applyStimulus(rand_frame(), 5, ok);
        capture(3 * NB, 3 * NB + 10, 1'b0);
        checks++;
        if (cap_got != 3 * NB || cap_gaps != 0 || cap_first != 0 || cap_cycles != 3 * NB) begin
            errors++;
            $display("[TB] FAIL b2b_stream: got beats=%0d gaps=%0d first=%0d cycles=%0d, want %0d 0 0 %0d",
                     cap_got, cap_gaps, cap_first, cap_cycles, 3 * NB, 3 * NB);
        end
        for (int i = 0; i < cap_got; i++) begin
            checks++;
            if (cap_data[i] !== exp_beat(model_q[i / NB], i % NB) ||
                cap_sof[i] !== (i % NB == 0) || cap_eof[i] !== (i % NB == NB - 1)) begin
                errors++;
                $display("[TB] FAIL b2b_beat %0d: got data=%h sof=%b eof=%b, want data=%h sof=%b eof=%b",
                         i, cap_data[i], cap_sof[i], cap_eof[i], exp_beat(model_q[i / NB], i % NB),
                         i % NB == 0, i % NB == NB - 1);
            end
        end
        retire_frames(cap_got / NB);
        checks++;
        if (frame_cnt !== model_cnt || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_end: got cnt=%h vld=%b, want %h 0", frame_cnt, out_valid, model_cnt);
        end
    endtask

    task automatic test_fill();
        bit ok;
        int acc = 0;
        for (int n = 0; n < 6; n++) begin
            applyStimulus(rand_frame(), 3, ok);
            if (ok) acc++;
        end
        @(negedge clk);
        checks++;
        if (acc != DEPTH + 1 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fill_accept: got accepted=%0d in_ready=%b, want %0d 0", acc, in_ready, DEPTH + 1);
        end
        capture(acc * NB, acc * NB + 10, 1'b0);
        checks++;
        if (cap_got != acc * NB || cap_gaps != 0) begin
            errors++;
            $display("[TB] FAIL fill_stream: got beats=%0d gaps=%0d, want %0d 0", cap_got, cap_gaps, acc * NB);
        end
        for (int i = 0; i < cap_got; i++) begin
            checks++;
            if (cap_data[i] !== exp_beat(model_q[i / NB], i % NB) ||
                cap_sof[i] !== (i % NB == 0) || cap_eof[i] !== (i % NB == NB - 1)) begin
                errors++;
                $display("[TB] FAIL fill_beat %0d: got data=%h sof=%b eof=%b, want data=%h",
                         i, cap_data[i], cap_sof[i], cap_eof[i], exp_beat(model_q[i / NB], i % NB));
            end
        end
        retire_frames(cap_got / NB);
        checks++;
        if (frame_cnt !== model_cnt) begin
            errors++;
            $display("[TB] FAIL fill_frame_cnt: got %h, want %h", frame_cnt, model_cnt);
        end
    endtask

    task automatic test_random();
        int acc = 0;
        fork
            begin
                bit ok;
                for (int n = 0; n < 8; n++) begin
                    applyStimulus(rand_frame(), 200, ok);
                    if (ok) acc++;
                end
            end
            capture(8 * NB, 1500, 1'b1);
        join
        checks++;
        if (acc != 8 || cap_got != 8 * NB) begin
            errors++;
            $display("[TB] FAIL rand_count: got accepted=%0d beats=%0d, want 8 %0d", acc, cap_got, 8 * NB);
        end
        for (int i = 0; i < cap_got; i++) begin
            checks++;
            if (cap_data[i] !== exp_beat(model_q[i / NB], i % NB) ||
                cap_sof[i] !== (i % NB == 0) || cap_eof[i] !== (i % NB == NB - 1)) begin
                errors++;
                $display("[TB] FAIL rand_beat %0d: got data=%h sof=%b eof=%b, want data=%h",
                         i, cap_data[i], cap_sof[i], cap_eof[i], exp_beat(model_q[i / NB], i % NB));
            end
        end
        retire_frames(cap_got / NB);
        checks++;
        if (frame_cnt !== model_cnt) begin
            errors++;
            $display("[TB] FAIL rand_frame_cnt: got %h, want %h", frame_cnt, model_cnt);
        end
    endtask

    task automatic test_midframe_reset();
        bit ok;
        for (int n = 0; n < 3; n++) applyStimulus(rand_frame(), 5, ok);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_beat(model_q[0], c)) begin
                errors++;
                $display("[TB] FAIL mrst_beat %0d: got vld=%b data=%h, want 1 %h",
                         c, out_valid, out_data, exp_beat(model_q[0], c));
            end
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_data !== exp_beat(model_q[0], 3)) begin
            errors++;
            $display("[TB] FAIL mrst_during: got rdy=%b data=%h, want 0 %h", in_ready, out_data, exp_beat(model_q[0], 3));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b0;
        model_q.delete();
        model_cnt = 16'h0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || frame_cnt !== model_cnt || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mrst_after: got vld=%b cnt=%h rdy=%b, want 0 0000 1", out_valid, frame_cnt, in_ready);
        end
        applyStimulus(rand_frame(), 5, ok);
        capture(NB, NB + 20, 1'b0);
        for (int i = 0; i < cap_got; i++) begin
            checks++;
            if (cap_data[i] !== exp_beat(model_q[0], i) || cap_sof[i] !== (i == 0) || cap_eof[i] !== (i == NB - 1)) begin
                errors++;
                $display("[TB] FAIL mrst_new_beat %0d: got data=%h sof=%b eof=%b, want data=%h",
                         i, cap_data[i], cap_sof[i], cap_eof[i], exp_beat(model_q[0], i));
            end
        end
        retire_frames(cap_got / NB);
        checks++;
        if (cap_got != NB || frame_cnt !== model_cnt || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mrst_new_end: got beats=%0d cnt=%h vld=%b, want %0d %h 0",
                     cap_got, frame_cnt, out_valid, NB, model_cnt);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        @(negedge clk);
        force dut.frame_cnt = 16'hFFFE;
        #1;
        release dut.frame_cnt;
        model_cnt = 16'hFFFE;
        for (int r = 0; r < 2; r++) begin
            applyStimulus(rand_frame(), 5, ok);
            capture(NB, NB + 20, 1'b0);
            for (int i = 0; i < cap_got; i++) begin
                checks++;
                if (cap_data[i] !== exp_beat(model_q[0], i) || cap_eof[i] !== (i == NB - 1)) begin
                    errors++;
                    $display("[TB] FAIL wrap_beat %0d: got data=%h eof=%b, want data=%h",
                             i, cap_data[i], cap_eof[i], exp_beat(model_q[0], i));
                end
            end
            retire_frames(cap_got / NB);
            checks++;
            if (frame_cnt !== model_cnt) begin
                errors++;
                $display("[TB] FAIL wrap_frame_cnt %0d: got %h, want %h", r, frame_cnt, model_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_fill();
        test_random();
        test_midframe_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
